// File: rtl/tm1637_pkg.sv
// Shared definitions for the TM1637 2-wire interface blocks.
//   - Command bytes understood by the chip.
//   - KEY_NONE: key byte reported when no key is pressed.
//   - state_e: key-scan sequencer states.
//   - pins_t / mk_pins: bundle of SCL/DIO pin controls.
package tm1637_pkg;

  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h8F;
  localparam logic [7:0] KEY_NONE       = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_START,
    ST_CMD,
    ST_CMD_ACK,
    ST_READ,
    ST_RD_ACK,
    ST_STOP
  } state_e;

  typedef struct packed {
    logic scl_en;
    logic scl_out;
    logic sda_en;
    logic sda_out;
  } pins_t;

  function automatic pins_t mk_pins(input logic scl_en, input logic scl_out,
                                    input logic sda_en, input logic sda_out);
    pins_t p;
    p.scl_en  = scl_en;
    p.scl_out = scl_out;
    p.sda_en  = sda_en;
    p.sda_out = sda_out;
    return p;
  endfunction

endpackage

// File: rtl/tm1637_phase_gen.sv
// Quarter-bit phase generator.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : synchronous clear, restarts the divider at phase 0
//   tick_o    : high on the last clk of each phase (every CLK_DIV cycles)
//   phase_o   : current quarter-bit phase 0..3
module tm1637_phase_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    phase_q;

  assign tick_o  = (cnt_q == CW'(CLK_DIV - 1));
  assign phase_o = phase_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else if (tick_o) begin
      cnt_q   <= '0;
      phase_q <= phase_q + 2'd1;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tm1637_keyscan.sv
// TM1637 key-scan reader.
// Requests the shared SCL/DIO bus, issues START, command 0x42 (LSB-first),
// checks the chip ACK, reads one key byte LSB-first, sends a NACK clock and
// a STOP, then reports the key byte.
//   scan_req, poll_en      : start one scan / enable periodic scans
//   bus_req, bus_gnt       : bus arbitration handshake
//   busy                   : scan in progress
//   key_valid, key_code    : key byte update pulse and value
//   key_down, key_event    : key pressed / code changed since last valid scan
//   ack_err                : chip did not ACK the command
//   scl_*, sda_*           : pin drive controls, sda_in is the sampled DIO
module tm1637_keyscan
  import tm1637_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int POLL_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_req,
  input  logic       poll_en,
  input  logic       bus_gnt,
  output logic       bus_req,
  output logic       busy,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_down,
  output logic       key_event,
  output logic       ack_err,
  output logic       scl_en,
  output logic       scl_out,
  output logic       sda_en,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam int PW = $clog2(POLL_CYCLES);

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic          ok_q, ok_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    shadow_q;
  logic [7:0]    key_code_q;
  logic          key_down_q, key_valid_q, key_event_q, ack_err_q;
  logic          busy_q;
  pins_t         pins_q, pins_d;

  logic          valid_d, event_d, ack_err_d, commit;
  logic          tick, bit_done, poll_hit;
  logic [1:0]    phase, ph_d;

  tm1637_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_d != state_q),
    .tick_o  (tick),
    .phase_o (phase)
  );

  assign bit_done = tick && (phase == 2'd3);
  assign poll_hit = poll_en && (poll_q == PW'(POLL_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    ok_d      = ok_q;
    poll_d    = poll_q;
    valid_d   = 1'b0;
    event_d   = 1'b0;
    ack_err_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_req || poll_hit) begin
          state_d = ST_REQ;
          poll_d  = '0;
        end else if (poll_en) begin
          poll_d = poll_q + PW'(1);
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_d = ST_START;
          bit_d   = 3'd0;
          ok_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick && phase == 2'd1) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (bit_done) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_CMD_ACK;
        end
      end
      ST_CMD_ACK: begin
        if (bit_done) begin
          if (!sda_in) begin
            state_d = ST_READ;
          end else begin
            state_d   = ST_STOP;
            ack_err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (bit_done) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_RD_ACK;
        end
      end
      ST_RD_ACK: begin
        if (bit_done) begin
          state_d = ST_STOP;
          ok_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick && phase == 2'd2) begin
          state_d = ST_IDLE;
          if (ok_q) begin
            commit  = 1'b1;
            valid_d = 1'b1;
            // key_code_q always holds the previous valid scan's code
            event_d = (shadow_q != key_code_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are computed for the upcoming state/phase so the registered
    // outputs line up with the sequencer rather than lagging one clk.
    if (state_d != state_q) ph_d = 2'd0;
    else if (tick)          ph_d = phase + 2'd1;
    else                    ph_d = phase;

    pins_d = mk_pins(1'b0, 1'b1, 1'b0, 1'b1);
    case (state_d)
      ST_START:   pins_d = mk_pins(1'b1, 1'b1, 1'b1, ph_d == 2'd0);
      ST_CMD:     pins_d = mk_pins(1'b1, ph_d[1], 1'b1, CMD_READ_KEYS[bit_d]);
      ST_CMD_ACK,
      ST_READ,
      ST_RD_ACK:  pins_d = mk_pins(1'b1, ph_d[1], 1'b0, 1'b1);
      ST_STOP:    pins_d = mk_pins(1'b1, ph_d != 2'd0, 1'b1, ph_d == 2'd2);
      default:    pins_d = mk_pins(1'b0, 1'b1, 1'b0, 1'b1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_q       <= 3'd0;
      ok_q        <= 1'b0;
      poll_q      <= '0;
      key_code_q  <= KEY_NONE;
      key_down_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_event_q <= 1'b0;
      ack_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      pins_q      <= mk_pins(1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      ok_q        <= ok_d;
      poll_q      <= poll_d;
      key_valid_q <= valid_d;
      key_event_q <= event_d;
      ack_err_q   <= ack_err_d;
      busy_q      <= (state_d != ST_IDLE);
      pins_q      <= pins_d;
      if (commit) begin
        key_code_q <= shadow_q;
        key_down_q <= (shadow_q != KEY_NONE);
      end
    end
  end

  // Key byte shadow: bit gi captured on the P3 sample of read bit gi.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q[gi] <= 1'b1;
        end else if (state_q == ST_READ && bit_done && bit_q == 3'(gi)) begin
          shadow_q[gi] <= sda_in;
        end
      end
    end
  endgenerate

  assign bus_req   = busy_q;
  assign busy      = busy_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
  assign key_event = key_event_q;
  assign ack_err   = ack_err_q;
  assign scl_en    = pins_q.scl_en;
  assign scl_out   = pins_q.scl_out;
  assign sda_en    = pins_q.sda_en;
  assign sda_out   = pins_q.sda_out;

endmodule

// File: tb/tb_tm1637_keyscan.sv
module tb_tm1637_keyscan;

  localparam int CLK_DIV     = 4;
  localparam int POLL_CYCLES = 1000;
  localparam int PIN_CYCLES  = 77 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_req = 1'b0;
  logic       poll_en = 1'b0;
  logic       bus_gnt = 1'b1;
  logic       sda_in;
  logic       bus_req, busy, key_valid, key_down, key_event, ack_err;
  logic       scl_en, scl_out, sda_en, sda_out;
  logic [7:0] key_code;

  always #5 clk = ~clk;

  tm1637_keyscan #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES)) dut (
    .clk(clk), .rst(rst), .scan_req(scan_req), .poll_en(poll_en),
    .bus_gnt(bus_gnt), .bus_req(bus_req), .busy(busy),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down),
    .key_event(key_event), .ack_err(ack_err), .scl_en(scl_en),
    .scl_out(scl_out), .sda_en(sda_en), .sda_out(sda_out), .sda_in(sda_in)
  );

  // Open-drain bus with pull-ups; the chip model can only pull DIO low.
  logic slave_sda = 1'b1;
  wire  scl_line = scl_en ? scl_out : 1'b1;
  wire  sda_line = (sda_en ? sda_out : 1'b1) & slave_sda;
  assign sda_in = sda_line;

  // Chip model: detects START/STOP, counts SCL rises, captures the command,
  // answers ACK/NACK and shifts out the key byte on SCL falls.
  logic [7:0] slave_key = 8'hFF;
  logic       slave_nack = 1'b0;
  logic [7:0] cmd_seen = 8'h00;
  logic       start_seen = 1'b0, stop_seen = 1'b0, started = 1'b0;
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         rises = 0;

  always @(negedge clk) begin
    if (rst) begin
      slave_sda = 1'b1;
      started   = 1'b0;
    end else if (scl_prev && scl_line && sda_prev && !sda_line) begin
      started = 1'b1; start_seen = 1'b1; rises = 0; slave_sda = 1'b1;
    end else if (scl_prev && scl_line && !sda_prev && sda_line) begin
      stop_seen = 1'b1; started = 1'b0; slave_sda = 1'b1;
    end else if (started && !scl_prev && scl_line) begin
      rises++;
      if (rises <= 8) cmd_seen[rises-1] = sda_line;
    end else if (started && scl_prev && !scl_line) begin
      if (slave_nack)                     slave_sda = 1'b1;
      else if (rises == 8)                slave_sda = 1'b0;
      else if (rises >= 9 && rises <= 16) slave_sda = slave_key[rises-9];
      else                                slave_sda = 1'b1;
    end
    scl_prev = scl_line;
    sda_prev = sda_line;
  end

  // Output monitor
  int         kv_cnt = 0, ae_cnt = 0, scan_cnt = 0, ev_orphan = 0;
  int         idle_run = 0, last_idle_run = 0, scl_cycles = 0, last_scl_cycles = 0;
  logic       last_event = 1'b0, busy_prev = 1'b0;
  logic [7:0] last_code = 8'h00;

  always @(negedge clk) begin
    if (key_valid) begin kv_cnt++; last_event = key_event; last_code = key_code; end
    if (key_event && !key_valid) ev_orphan++;
    if (ack_err) ae_cnt++;
    if (busy && !busy_prev) begin scan_cnt++; last_idle_run = idle_run; scl_cycles = 0; end
    if (busy) idle_run = 0; else idle_run++;
    if (scl_en) scl_cycles++;
    if (!busy && busy_prev) last_scl_cycles = scl_cycles;
    busy_prev = busy;
  end

  // Reference model: result of one scan from the chip's answer.
  logic [7:0] m_prev = 8'hFF, m_code = 8'hFF;
  logic       m_event = 1'b0;
  int         m_kv = 0, m_ae = 0;

  task automatic model_scan(input logic [7:0] key, input logic nack);
    if (nack) begin
      m_ae++;
    end else begin
      m_event = (key != m_prev);
      m_code  = key;
      m_prev  = key;
      m_kv++;
    end
  endtask

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_scan_end();
    int t = 0;
    while (!busy && t < 3000) begin @(negedge clk); t++; end
    while (busy && t < 6000) begin @(negedge clk); t++; end
    chk("scan_timeout", (t < 6000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_scan(input string tag, input logic nack);
    chk({tag, "_kv_cnt"}, kv_cnt, m_kv);
    chk({tag, "_ae_cnt"}, ae_cnt, m_ae);
    chk({tag, "_key_code"}, key_code, m_code);
    chk({tag, "_key_down"}, key_down, (m_code != 8'hFF) ? 1 : 0);
    chk({tag, "_cmd_bits"}, cmd_seen, 8'h42);
    chk({tag, "_stop"}, stop_seen, 1);
    chk({tag, "_released"}, {scl_en, sda_en, scl_line, sda_line}, 4'b0011);
    if (!nack) begin
      chk({tag, "_event"}, last_event, m_event);
      chk({tag, "_valid_code"}, last_code, m_code);
      chk({tag, "_pin_cycles"}, last_scl_cycles, PIN_CYCLES);
    end
  endtask

  task automatic do_scan(input string tag, input logic [7:0] key, input logic nack,
                         input logic extra_req);
    int sc0;
    slave_key = key; slave_nack = nack;
    stop_seen = 1'b0; start_seen = 1'b0; cmd_seen = 8'h00;
    sc0 = scan_cnt;
    @(negedge clk) scan_req = 1'b1;
    @(negedge clk) scan_req = 1'b0;
    if (extra_req) begin
      repeat ($urandom_range(5, 250)) @(negedge clk);
      scan_req = 1'b1;
      @(negedge clk) scan_req = 1'b0;
    end
    wait_scan_end();
    model_scan(key, nack);
    $display("scan %s key=%02h nack=%0d -> valid=%0d code=%02h event=%0d ack_err_cnt=%0d",
             tag, key, nack, kv_cnt, key_code, last_event, ae_cnt);
    check_scan(tag, nack);
    chk({tag, "_one_scan"}, scan_cnt - sc0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic ok;
    int sc0, kv0;
    logic [7:0] k;
    logic nk;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {scl_en, scl_out, sda_en, sda_out}, 4'b0101);
    chk("rst_key_code", key_code, 8'hFF);
    chk("rst_flags", {key_down, key_valid, key_event, ack_err}, 4'b0000);

    // Directed scans
    do_scan("f7_first", 8'hF7, 1'b0, 1'b0);
    do_scan("f7_repeat", 8'hF7, 1'b0, 1'b0);
    do_scan("ff_release", 8'hFF, 1'b0, 1'b0);
    do_scan("f7_again", 8'hF7, 1'b0, 1'b0);
    do_scan("nack", 8'h12, 1'b1, 1'b0);

    // Grant withheld for 200 cycles
    bus_gnt = 1'b0;
    slave_key = 8'h5A; slave_nack = 1'b0; stop_seen = 1'b0; cmd_seen = 8'h00;
    @(negedge clk) scan_req = 1'b1;
    @(negedge clk) scan_req = 1'b0;
    ok = 1'b1;
    repeat (200) begin
      if (!(bus_req && busy && !scl_en && !sda_en)) ok = 1'b0;
      @(negedge clk);
    end
    chk("gnt_wait_hold", ok, 1);
    bus_gnt = 1'b1;
    t = 0;
    while (!scl_en && t < 50) begin @(negedge clk); t++; end
    chk("gnt_to_start", (t >= 1 && t <= CLK_DIV) ? 1 : 0, 1);
    wait_scan_end();
    model_scan(8'h5A, 1'b0);
    $display("scan gnt_delay key=5a latency=%0d code=%02h", t, key_code);
    check_scan("gnt_delay", 1'b0);

    // Periodic polling
    slave_key = 8'h3C; slave_nack = 1'b0;
    sc0 = scan_cnt;
    poll_en = 1'b1;
    wait_scan_end();
    model_scan(8'h3C, 1'b0);
    wait_scan_end();
    model_scan(8'h3C, 1'b0);
    $display("poll idle_run=%0d scans=%0d code=%02h", last_idle_run, scan_cnt - sc0, key_code);
    chk("poll_interval", last_idle_run, POLL_CYCLES);
    chk("poll_two_scans", scan_cnt - sc0, 2);
    chk("poll_code", key_code, 8'h3C);
    // scan_req on the expiry cycle: the first low sample above follows the
    // IDLE entry edge, so expiry is decided on the 1000th edge after it.
    repeat (POLL_CYCLES - 3) @(negedge clk);
    sc0 = scan_cnt;
    scan_req = 1'b1;
    @(negedge clk) scan_req = 1'b0;
    poll_en = 1'b0;
    wait_scan_end();
    model_scan(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    $display("poll coincident idle_run=%0d scans=%0d", last_idle_run, scan_cnt - sc0);
    chk("poll_coincident_one", scan_cnt - sc0, 1);
    chk("poll_coincident_run", last_idle_run, POLL_CYCLES);
    chk("poll_kv_cnt", kv_cnt, m_kv);

    // Reset during READ bit 4
    slave_key = 8'h81; slave_nack = 1'b0; start_seen = 1'b0;
    @(negedge clk) scan_req = 1'b1;
    @(negedge clk) scan_req = 1'b0;
    t = 0;
    while (!(start_seen && rises >= 14) && t < 3000) begin @(negedge clk); t++; end
    chk("rst_mid_reach", (t < 3000) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_prev = 8'hFF; m_code = 8'hFF;
    $display("reset mid-read bus_req=%0d busy=%0d scl_en=%0d sda_en=%0d code=%02h",
             bus_req, busy, scl_en, sda_en, key_code);
    chk("rst_mid_bus", {scl_en, sda_en, bus_req, busy}, 4'b0000);
    chk("rst_mid_code", key_code, 8'hFF);
    chk("rst_mid_down", key_down, 0);
    kv0 = kv_cnt;
    repeat (400) @(negedge clk);
    chk("rst_mid_no_valid", kv_cnt, kv0);
    chk("rst_mid_idle", busy, 0);

    // Randomized scans, sometimes with a redundant scan_req mid-scan
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       k = 8'hFF;
        1:       k = m_prev;
        default: k = 8'($urandom_range(0, 255));
      endcase
      nk = ($urandom_range(0, 4) == 0);
      do_scan($sformatf("rnd%0d", i), k, nk, $urandom_range(0, 1) == 1);
    end

    chk("orphan_event", ev_orphan, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
